// File: rtl/axi_switch_pkg.sv
// Shared types and helpers for the AXI switch W-path blocks.
package axi_switch_pkg;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Control half of a destination output register; src and dat widths are
    // set by the instantiating module's parameters.
    typedef struct packed {
        logic vld;
        logic last;
    } wCtl_t;

endpackage

// File: rtl/idx_fifo.sv
// Small synchronous FIFO of index values used to record AW grant order.
module idx_fifo
    import axi_switch_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = idxWidth(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             doPush, doPop;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count_q == CntW'(DEPTH));
        empty   = (count_q == '0);
        head    = mem_q[rdPtr_q];
        doPush  = push && !full;
        doPop   = pop && !empty;
        wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        unique case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData;
            end
        end
    end

endmodule

// File: rtl/w_route_scheduler.sv
// Burst-locked W scheduler: steers each source's W beats to destinations in AW
// grant order, delivering whole bursts per destination without interleave.
module w_route_scheduler
    import axi_switch_pkg::*;
#(
    parameter int unsigned S     = 2,
    parameter int unsigned D     = 2,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LOG_S = idxWidth(S),
    parameter int unsigned LOG_D = idxWidth(D)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             awVld_i,
    input  logic [LOG_S-1:0] awSrc_i,
    input  logic [LOG_D-1:0] awDst_i,
    output logic             awRdy_o,
    input  logic [S-1:0]     srcWVld_i,
    input  logic [WIDTH-1:0] srcWDat_i [S],
    input  logic [S-1:0]     srcWLast_i,
    output logic [S-1:0]     srcWRdy_o,
    output logic [D-1:0]     dstWVld_o,
    output logic [WIDTH-1:0] dstWDat_o [D],
    output logic [D-1:0]     dstWLast_o,
    output logic [LOG_S-1:0] dstWSrc_o [D],
    input  logic [D-1:0]     dstWRdy_i
);

    logic [LOG_D-1:0] srcHead [S];
    logic [S-1:0]     srcFull, srcEmpty, srcPush, srcPop;
    logic [LOG_S-1:0] dstHead [D];
    logic [D-1:0]     dstFull, dstEmpty, dstPush, dstPop;

    logic             awPush;
    logic [S-1:0]     match, xfer;
    logic [D-1:0]     slotFree;

    logic [D-1:0]     dXfer, dLast;
    logic [LOG_S-1:0] dSrc [D];
    logic [WIDTH-1:0] dDat [D];

    wCtl_t            oCtl_q [D];
    wCtl_t            oCtl_d [D];
    logic [LOG_S-1:0] oSrc_q [D];
    logic [LOG_S-1:0] oSrc_d [D];
    logic [WIDTH-1:0] oDat_q [D];
    logic [WIDTH-1:0] oDat_d [D];

    for (genvar s = 0; s < S; s++) begin : gSrcQ
        idx_fifo #(
            .WIDTH (LOG_D),
            .DEPTH (DEPTH)
        ) uSrcQ (
            .clk      (clk),
            .rstn     (rstn),
            .push     (srcPush[s]),
            .pushData (awDst_i),
            .pop      (srcPop[s]),
            .head     (srcHead[s]),
            .full     (srcFull[s]),
            .empty    (srcEmpty[s])
        );
    end

    for (genvar d = 0; d < D; d++) begin : gDstQ
        idx_fifo #(
            .WIDTH (LOG_S),
            .DEPTH (DEPTH)
        ) uDstQ (
            .clk      (clk),
            .rstn     (rstn),
            .push     (dstPush[d]),
            .pushData (awSrc_i),
            .pop      (dstPop[d]),
            .head     (dstHead[d]),
            .full     (dstFull[d]),
            .empty    (dstEmpty[d])
        );
    end

    // Occupancy-only acceptance: a same-cycle WLAST pop does not free a slot.
    always_comb begin
        awRdy_o = 1'b0;
        if ((32'(awSrc_i) < S) && (32'(awDst_i) < D)) begin
            awRdy_o = !srcFull[awSrc_i] && !dstFull[awDst_i];
        end
        awPush = awVld_i && awRdy_o;
        for (int s = 0; s < S; s++) begin
            srcPush[s] = awPush && (awSrc_i == LOG_S'(s));
        end
        for (int d = 0; d < D; d++) begin
            dstPush[d] = awPush && (awDst_i == LOG_D'(d));
        end
    end

    always_comb begin
        for (int d = 0; d < D; d++) begin
            slotFree[d] = !oCtl_q[d].vld || dstWRdy_i[d];
        end
    end

    // A source may send only when it is at the head of its target's queue.
    always_comb begin
        for (int s = 0; s < S; s++) begin
            match[s]     = !srcEmpty[s] && !dstEmpty[srcHead[s]] &&
                           (dstHead[srcHead[s]] == LOG_S'(s));
            srcWRdy_o[s] = match[s] && slotFree[srcHead[s]];
        end
    end

    always_comb begin
        xfer   = srcWVld_i & srcWRdy_o;
        srcPop = xfer & srcWLast_i;
    end

    // Gather per-destination transfers; route matching guarantees one source each.
    always_comb begin
        dXfer  = '0;
        dLast  = '0;
        dstPop = '0;
        for (int d = 0; d < D; d++) begin
            dSrc[d] = '0;
            dDat[d] = '0;
        end
        for (int s = 0; s < S; s++) begin
            if (xfer[s]) begin
                dXfer[srcHead[s]]  = 1'b1;
                dLast[srcHead[s]]  = srcWLast_i[s];
                dSrc[srcHead[s]]   = LOG_S'(s);
                dDat[srcHead[s]]   = srcWDat_i[s];
                dstPop[srcHead[s]] = srcWLast_i[s];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < D; d++) begin
            oCtl_d[d] = oCtl_q[d];
            oSrc_d[d] = oSrc_q[d];
            oDat_d[d] = oDat_q[d];
            if (dXfer[d]) begin
                oCtl_d[d].vld  = 1'b1;
                oCtl_d[d].last = dLast[d];
                oSrc_d[d]      = dSrc[d];
                oDat_d[d]      = dDat[d];
            end else if (dstWRdy_i[d]) begin
                oCtl_d[d].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < D; d++) begin
                oCtl_q[d] <= '0;
                oSrc_q[d] <= '0;
                oDat_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < D; d++) begin
                oCtl_q[d] <= oCtl_d[d];
                oSrc_q[d] <= oSrc_d[d];
                oDat_q[d] <= oDat_d[d];
            end
        end
    end

    always_comb begin
        for (int d = 0; d < D; d++) begin
            dstWVld_o[d]  = oCtl_q[d].vld;
            dstWLast_o[d] = oCtl_q[d].last;
            dstWSrc_o[d]  = oSrc_q[d];
            dstWDat_o[d]  = oDat_q[d];
        end
    end

endmodule

// File: tb/tb_w_route_scheduler.sv
// Scoreboard bench for w_route_scheduler: bursts are queued per source and the
// expected per-destination beat stream is built in AW order.
module tb_w_route_scheduler;

    logic        clk;
    logic        rstn;
    logic        awVld;
    logic [0:0]  awSrc;
    logic [0:0]  awDst;
    logic        awRdy;
    logic [1:0]  srcWVld;
    logic [63:0] srcWDat [2];
    logic [1:0]  srcWLast;
    logic [1:0]  srcWRdy;
    logic [1:0]  dstWVld;
    logic [63:0] dstWDat [2];
    logic [1:0]  dstWLast;
    logic [0:0]  dstWSrc [2];
    logic [1:0]  dstWRdy;

    typedef struct {
        logic [63:0] dat;
        logic        last;
    } beat_t;

    typedef struct {
        logic [63:0] dat;
        logic        last;
        logic        src;
    } exp_t;

    beat_t srcBeats [2][$];
    exp_t  expQ [2][$];
    int    vecs = 0;
    int    errs = 0;
    int    seen [2];
    int    burstId = 0;

    w_route_scheduler #(
        .S     (2),
        .D     (2),
        .WIDTH (64),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .awVld_i    (awVld),
        .awSrc_i    (awSrc),
        .awDst_i    (awDst),
        .awRdy_o    (awRdy),
        .srcWVld_i  (srcWVld),
        .srcWDat_i  (srcWDat),
        .srcWLast_i (srcWLast),
        .srcWRdy_o  (srcWRdy),
        .dstWVld_o  (dstWVld),
        .dstWDat_o  (dstWDat),
        .dstWLast_o (dstWLast),
        .dstWSrc_o  (dstWSrc),
        .dstWRdy_i  (dstWRdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy();
        return (srcBeats[0].size() + srcBeats[1].size() + expQ[0].size() +
                expQ[1].size()) != 0;
    endfunction

    task automatic queueBurst(input int s, input int d, input int len);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < len; i++) begin
            b.dat  = {$urandom(), 16'(burstId), 8'(s), 8'(i)};
            b.last = (i == len - 1);
            e.dat  = b.dat;
            e.last = b.last;
            e.src  = 1'(s);
            srcBeats[s].push_back(b);
            expQ[d].push_back(e);
        end
        burstId++;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issueAw(input int s, input int d);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        awVld = 1'b1;
        awSrc = 1'(s);
        awDst = 1'(d);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = awRdy;
            n++;
            @(posedge clk);
            #1;
        end
        awVld = 1'b0;
        checkVal($sformatf("awAccept s%0d d%0d", s, d), 64'(ok), 64'd1);
    endtask

    task automatic sync();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy() && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, " drained"}, 64'(busy()), 64'd0);
        @(negedge clk);
        checkVal({tag, " rdyIdle"}, 64'(srcWRdy), 64'd0);
        sync();
    endtask

    // Source drivers: present the head beat, retire it when accepted.
    initial begin : driver
        logic [1:0] acc;
        srcWVld  = '0;
        srcWLast = '0;
        srcWDat[0] = '0;
        srcWDat[1] = '0;
        forever begin
            @(negedge clk);
            acc = srcWVld & srcWRdy;
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (acc[s] && srcBeats[s].size() > 0) void'(srcBeats[s].pop_front());
                if (srcBeats[s].size() > 0) begin
                    srcWVld[s]  = 1'b1;
                    srcWDat[s]  = srcBeats[s][0].dat;
                    srcWLast[s] = srcBeats[s][0].last;
                end else begin
                    srcWVld[s]  = 1'b0;
                    srcWLast[s] = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        seen[0] = 0;
        seen[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (dstWVld[d] && dstWRdy[d]) begin
                    if (expQ[d].size() == 0) begin
                        checkVal($sformatf("unexpected beat d%0d", d), 64'd1, 64'd0);
                    end else begin
                        e = expQ[d].pop_front();
                        checkVal($sformatf("dat d%0d", d), dstWDat[d], e.dat);
                        checkVal($sformatf("last d%0d", d), 64'(dstWLast[d]), 64'(e.last));
                        checkVal($sformatf("src d%0d", d), 64'(dstWSrc[d]), 64'(e.src));
                        seen[d]++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", errs);
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        rstn    = 1'b0;
        awVld   = 1'b0;
        awSrc   = '0;
        awDst   = '0;
        dstWRdy = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst dstWVld", 64'(dstWVld), 64'd0);
        checkVal("rst dstWDat0", dstWDat[0], 64'd0);
        checkVal("rst srcWRdy", 64'(srcWRdy), 64'd0);
        rstn = 1'b1;
        sync();
        checkVal("rst awRdy", 64'(awRdy), 64'd1);
        checkVal("rst dstWLast", 64'(dstWLast), 64'd0);

        // Single 4-beat burst s0 -> d1.
        queueBurst(0, 1, 4);
        sync();
        issueAw(0, 1);
        waitIdle("single");

        // Two sources contend for d0; bursts must not interleave.
        queueBurst(0, 0, 2);
        queueBurst(1, 0, 2);
        sync();
        issueAw(0, 0);
        issueAw(1, 0);
        waitIdle("contend");

        // One source, two bursts to different destinations, in AW order.
        queueBurst(0, 0, 3);
        queueBurst(0, 1, 3);
        sync();
        issueAw(0, 0);
        issueAw(0, 1);
        waitIdle("split");

        // Parallel streams s0->d0 and s1->d1 at one beat per cycle each.
        queueBurst(0, 0, 4);
        queueBurst(1, 1, 4);
        sync();
        issueAw(0, 0);
        issueAw(1, 1);
        @(negedge clk);
        checkVal("par k0", 64'(dstWVld), 64'b01);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checkVal($sformatf("par k%0d", k), 64'(dstWVld), 64'b11);
        end
        @(negedge clk);
        checkVal("par k4", 64'(dstWVld), 64'b10);
        waitIdle("parallel");

        // Fill both FIFOs, then a single WLAST pop re-opens AW.
        for (int i = 0; i < 4; i++) issueAw(0, 0);
        awVld = 1'b1;
        awSrc = 1'b0;
        awDst = 1'b0;
        @(negedge clk);
        checkVal("awFull", 64'(awRdy), 64'd0);
        queueBurst(0, 0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awRdy && n < 10);
        checkVal("awReRaise cycles", 64'(n), 64'd2);
        @(posedge clk);
        #1;
        awVld = 1'b0;
        for (int i = 0; i < 4; i++) queueBurst(0, 0, 1);
        waitIdle("full");

        // W before AW stalls, then drains in order once the record lands.
        queueBurst(1, 1, 2);
        sync();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkVal($sformatf("earlyW vld k%0d", k), 64'(srcWVld[1]), 64'd1);
            checkVal($sformatf("earlyW rdy k%0d", k), 64'(srcWRdy[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        issueAw(1, 1);
        waitIdle("earlyW");

        // Destination backpressure mid-burst.
        queueBurst(0, 0, 6);
        sync();
        seen[0] = 0;
        issueAw(0, 0);
        n = 0;
        while (seen[0] < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        dstWRdy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkVal($sformatf("bp vld k%0d", k), 64'(dstWVld[0]), 64'd1);
            checkVal($sformatf("bp dat k%0d", k), dstWDat[0], expQ[0][0].dat);
            checkVal($sformatf("bp rdy k%0d", k), 64'(srcWRdy[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        dstWRdy[0] = 1'b1;
        waitIdle("backpressure");

        // Asynchronous reset mid-burst discards everything.
        queueBurst(0, 0, 6);
        sync();
        seen[0] = 0;
        issueAw(0, 0);
        n = 0;
        while (seen[0] < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #3;
        rstn = 1'b0;
        srcBeats[0].delete();
        expQ[0].delete();
        #1;
        checkVal("midRst dstWVld", 64'(dstWVld), 64'd0);
        checkVal("midRst dstWLast", 64'(dstWLast), 64'd0);
        checkVal("midRst dstWDat0", dstWDat[0], 64'd0);
        checkVal("midRst dstWSrc0", 64'(dstWSrc[0]), 64'd0);
        checkVal("midRst srcWRdy", 64'(srcWRdy), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(negedge clk);
        checkVal("postRst awRdy", 64'(awRdy), 64'd1);
        checkVal("postRst dstWVld", 64'(dstWVld), 64'd0);
        sync();
        queueBurst(1, 0, 2);
        sync();
        issueAw(1, 0);
        waitIdle("postRst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
